// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types, defaults and the round-robin pick helper
// for the shared-divider controller.
package div_share_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_IDW     = 3;
    localparam int DEF_TIMEOUT = 64;
    localparam int TIMEOUT_W   = $clog2(DEF_TIMEOUT);
    localparam int MAX_REQ     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of req at or above ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int unsigned        n
    );
        pick_t      p;
        logic [2:0] j;
        p = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = 3'((32'(ptr) + k) % n);
            if (k < n && !p.found && req[j]) begin
                p.found = 1'b1;
                p.idx   = j;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// div_share_ctrl_if: requester, response and divider-side signals of the
// shared-divider controller; master is the controller's view.
interface div_share_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 3
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic                  rsp_zero_err;
    logic                  rsp_timeout;

    logic                  div_start;
    logic [WIDTH-1:0]      div_dividend;
    logic [WIDTH-1:0]      div_divisor;
    logic [WIDTH-1:0]      div_quotient;
    logic [WIDTH-1:0]      div_remainder;
    logic                  div_valid;

    modport master (
        input  req_valid, req_dividend, req_divisor,
        output req_ready,
        output rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
        output rsp_zero_err, rsp_timeout,
        input  rsp_ready,
        output div_start, div_dividend, div_divisor,
        input  div_quotient, div_remainder, div_valid
    );

    modport slave (
        output req_valid, req_dividend, req_divisor,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder,
        input  rsp_zero_err, rsp_timeout,
        output rsp_ready,
        input  div_start, div_dividend, div_divisor,
        output div_quotient, div_remainder, div_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one requester,
// searching upward from ptr with wrap.
module rr_arbiter
    import div_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    pick_t              pick;
    logic [MAX_REQ-1:0] req_w;

    always_comb begin
        req_w             = '0;
        req_w[NREQ-1:0]   = req;
        pick              = rr_pick(req_w, 3'(ptr), NREQ);
        found             = pick.found;
        idx               = IDW'(pick.idx);
        gnt               = '0;
        if (pick.found) begin
            gnt = NREQ'(1) << pick.idx;
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one iterative divider between NREQ requesters,
// with local divide-by-zero handling and a completion watchdog.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int IDW     = DEF_IDW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic             clk,
    input logic             rst_n,
    div_share_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zero_q, zero_d;
    logic             tmo_q, tmo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gidx;
    logic             found;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [NREQ-1:0]  req_ready;
    logic             div_start;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .idx   (gidx),
        .found (found)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_a = bus.req_dividend[i*WIDTH +: WIDTH];
                op_b = bus.req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        q_d       = q_q;
        r_d       = r_q;
        zero_d    = zero_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = gnt;
                    id_d      = gidx;
                    a_d       = op_a;
                    b_d       = op_b;
                    tmo_d     = 1'b0;
                    if (op_b == '0) begin
                        q_d     = '0;
                        r_d     = op_a;
                        zero_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // First WAIT cycle may still see the previous result's valid.
                if (cnt_q != '0 && bus.div_valid) begin
                    q_d     = bus.div_quotient;
                    r_d     = bus.div_remainder;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    q_d     = '0;
                    r_d     = '0;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    zero_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            zero_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_id        = id_q;
    assign bus.rsp_quotient  = q_q;
    assign bus.rsp_remainder = r_q;
    assign bus.rsp_zero_err  = zero_q;
    assign bus.rsp_timeout   = tmo_q;
    assign bus.div_start     = div_start;
    assign bus.div_dividend  = a_q;
    assign bus.div_divisor   = b_q;

endmodule
